// File: rtl/sm3_pkg.sv
// sm3_pkg: shared types and constants for the SM3 padding stage.
//   pad_st_e       : padding FSM states
//   SM3_BLK_WORDS  : words per 512-bit block
//   SM3_PAD_BYTE   : the single 1-bit marker byte appended after the message
//   SM3_LEN_IDX    : word index where the 64-bit bit-length begins
//   mask_legal()   : true for MSB-contiguous byte masks
package sm3_pkg;
  typedef enum logic [2:0] {DATA, PAD_80, ZERO, LEN_HI, LEN_LO} pad_st_e;

  localparam int         SM3_BLK_WORDS = 16;
  localparam logic [7:0] SM3_PAD_BYTE  = 8'h80;
  localparam logic [3:0] SM3_LEN_IDX   = 4'd14;

  function automatic logic mask_legal(input logic [3:0] m);
    return (m == 4'b1111) || (m == 4'b1110) || (m == 4'b1100) ||
           (m == 4'b1000) || (m == 4'b0000);
  endfunction
endpackage

// File: rtl/sm3_pad_core_if.sv
// sm3_pad_core_if: message-in / padded-word-out stream bundle.
//   msg_inpt_* : raw big-endian words with byte-valid mask and last flag
//   pad_otpt_* : padded 16-word blocks toward the message expander
//   pad_err_o  : sticky mask error (present only with SM3_PAD_ERR_CHK_EN)
// slave = padding core view, master = producer/consumer view.
interface sm3_pad_core_if;
  logic [31:0] msg_inpt_d_i;
  logic [3:0]  msg_inpt_vld_byte_i;
  logic        msg_inpt_vld_i;
  logic        msg_inpt_lst_i;
  logic        msg_inpt_rdy_o;
  logic [31:0] pad_otpt_d_o;
  logic        pad_otpt_vld_o;
  logic        pad_otpt_lst_o;
  logic        pad_otpt_ena_i;
`ifdef SM3_PAD_ERR_CHK_EN
  logic        pad_err_o;
`endif

  modport slave (
    input  msg_inpt_d_i, msg_inpt_vld_byte_i, msg_inpt_vld_i, msg_inpt_lst_i,
    input  pad_otpt_ena_i,
`ifdef SM3_PAD_ERR_CHK_EN
    output pad_err_o,
`endif
    output msg_inpt_rdy_o, pad_otpt_d_o, pad_otpt_vld_o, pad_otpt_lst_o
  );

  modport master (
    output msg_inpt_d_i, msg_inpt_vld_byte_i, msg_inpt_vld_i, msg_inpt_lst_i,
    output pad_otpt_ena_i,
`ifdef SM3_PAD_ERR_CHK_EN
    input  pad_err_o,
`endif
    input  msg_inpt_rdy_o, pad_otpt_d_o, pad_otpt_vld_o, pad_otpt_lst_o
  );
endinterface

// File: rtl/sm3_pad_byte_ins.sv
// sm3_pad_byte_ins: combinational marker insertion for a final beat.
//   d    in  32 : message word, byte 0 in [31:24]
//   mask in  4  : byte-valid mask, bit 3 = byte 0
//   word out 32 : leading valid bytes kept, 0x80 at first invalid byte, rest 0
//   cnt  out 3  : number of valid bytes (popcount of mask)
// A full mask yields the word unchanged; the caller decides what to emit.
module sm3_pad_byte_ins
  import sm3_pkg::*;
(
  input  logic [31:0] d,
  input  logic [3:0]  mask,
  output logic [31:0] word,
  output logic [2:0]  cnt
);
  always_comb begin
    logic hit;
    word = '0;
    cnt  = '0;
    hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, mask[3-i]};
      // Only the MSB-contiguous prefix survives; bytes past the marker are zeroed.
      if (!hit && mask[3-i]) begin
        word[31-8*i -: 8] = d[31-8*i -: 8];
      end else if (!hit) begin
        word[31-8*i -: 8] = SM3_PAD_BYTE;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sm3_pad_core.sv
// sm3_pad_core: SM3 message padding. Forwards message words, appends the
// 0x80 marker, zero fill and 64-bit bit length, emitting whole 16-word blocks.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sm3_pad_core_if.slave (message in, padded words out)
//   LEN_W    : bit-length counter width (64 for SM3)
// Optional: SM3_PAD_ERR_CHK_EN adds the sticky pad_err_o mask checker.
module sm3_pad_core
  import sm3_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  sm3_pad_core_if.slave bus
);
  localparam int IDX_W = $clog2(SM3_BLK_WORDS);

  pad_st_e          st_q, st_d;
  logic [IDX_W-1:0] idx_q, nidx;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      d_q, d_d;
  logic             vld_q, vld_d, lst_q, lst_d;
  logic             xfer, adv, rdy, acc, full;
  logic [31:0]      ins_w;
  logic [2:0]       ins_n;
  logic [63:0]      len64;

  sm3_pad_byte_ins u_ins (
    .d    (bus.msg_inpt_d_i),
    .mask (bus.msg_inpt_vld_byte_i),
    .word (ins_w),
    .cnt  (ins_n)
  );

  assign xfer  = vld_q & bus.pad_otpt_ena_i;
  assign adv   = !vld_q | bus.pad_otpt_ena_i;  // output register may load
  assign rdy   = (st_q == DATA) && adv && !rst;
  assign acc   = bus.msg_inpt_vld_i && rdy;
  assign full  = (ins_n == 3'd4);
  // Index of the word loaded this cycle: the held word leaves if it transfers.
  assign nidx  = idx_q + {{(IDX_W-1){1'b0}}, xfer};
  assign len64 = 64'(len_q);

  assign bus.msg_inpt_rdy_o = rdy;
  assign bus.pad_otpt_d_o   = d_q;
  assign bus.pad_otpt_vld_o = vld_q;
  assign bus.pad_otpt_lst_o = lst_q;

  // After loading a padding word at index i: if the next slot is the length
  // slot, go straight to LEN_HI, otherwise keep zero-filling.
  function automatic pad_st_e after_pad(input logic [IDX_W-1:0] i);
    return (i == SM3_LEN_IDX - 4'd1) ? LEN_HI : ZERO;
  endfunction

  always_comb begin
    st_d  = st_q;
    d_d   = d_q;
    vld_d = vld_q;
    lst_d = lst_q;
    // Length restarts when the final length word leaves, even if a new
    // message's first beat is accepted in the same cycle.
    len_d = (xfer && lst_q) ? '0 : len_q;
    if (adv) begin
      vld_d = 1'b0;
      lst_d = 1'b0;
      unique case (st_q)
        DATA: if (acc) begin
          vld_d = 1'b1;
          len_d = len_d + (LEN_W'(ins_n) << 3);
          d_d   = (!bus.msg_inpt_lst_i || full) ? bus.msg_inpt_d_i : ins_w;
          if (bus.msg_inpt_lst_i) st_d = full ? PAD_80 : after_pad(nidx);
        end
        PAD_80: begin
          vld_d = 1'b1;
          d_d   = {SM3_PAD_BYTE, 24'h0};
          st_d  = after_pad(nidx);
        end
        ZERO: begin
          vld_d = 1'b1;
          d_d   = '0;
          st_d  = after_pad(nidx);
        end
        LEN_HI: begin
          vld_d = 1'b1;
          d_d   = len64[63:32];
          st_d  = LEN_LO;
        end
        LEN_LO: begin
          vld_d = 1'b1;
          lst_d = 1'b1;
          d_d   = len64[31:0];
          st_d  = DATA;
        end
        default: st_d = DATA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= DATA;
      idx_q <= '0;
      len_q <= '0;
      d_q   <= '0;
      vld_q <= 1'b0;
      lst_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      len_q <= len_d;
      d_q   <= d_d;
      vld_q <= vld_d;
      lst_q <= lst_d;
      if (xfer) idx_q <= lst_q ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SM3_PAD_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (acc && (!mask_legal(bus.msg_inpt_vld_byte_i) ||
                     (bus.msg_inpt_vld_byte_i == 4'b0000 && !bus.msg_inpt_lst_i)))
      err_q <= 1'b1;
  end
  assign bus.pad_err_o = err_q;
`endif
endmodule

// File: tb/tb_sm3_pad_core.sv
// tb_sm3_pad_core: directed bench for sm3_pad_core with hand-computed padded
// blocks, optional random back-pressure and a mid-message reset.
module tb_sm3_pad_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm3_pad_core_if bus();
  sm3_pad_core #(.LEN_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_d[$];
  bit          rnd_ena = 1'b0;
  int          stall_bad = 0;
  int          rdy_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // downstream ready: held high or randomly toggled
  initial begin
    bus.pad_otpt_ena_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.pad_otpt_ena_i = rnd_ena ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // output monitor: collects transfers, checks hold-while-stalled
  initial begin
    logic pv;
    logic [31:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) pv = 1'b0;
      else begin
        if (pv && !(bus.pad_otpt_vld_o && bus.pad_otpt_d_o === pd)) stall_bad++;
        if (bus.pad_otpt_vld_o && bus.pad_otpt_ena_i) begin
          got_d.push_back(bus.pad_otpt_d_o);
          got_l.push_back(bus.pad_otpt_lst_o);
        end
        pv = bus.pad_otpt_vld_o && !bus.pad_otpt_ena_i;
        pd = bus.pad_otpt_d_o;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] m, input logic lst);
    bit ok;
    ok = 1'b0;
    bus.msg_inpt_d_i        = d;
    bus.msg_inpt_vld_byte_i = m;
    bus.msg_inpt_lst_i      = lst;
    bus.msg_inpt_vld_i      = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.msg_inpt_rdy_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.msg_inpt_vld_i = 1'b0;
    check("send_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_d.push_back(32'h0);
  endtask

  // wait for the final word, checking rdy stays low while padding, then compare
  task automatic finish_msg(input string name);
    bit done;
    logic [31:0] o;
    logic        ol;
    done = 1'b0;
    rdy_bad = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.msg_inpt_rdy_o && !(bus.pad_otpt_vld_o && bus.pad_otpt_lst_o)) rdy_bad++;
      if (bus.pad_otpt_vld_o && bus.pad_otpt_lst_o && bus.pad_otpt_ena_i) done = 1'b1;
      @(posedge clk); #1;
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_rdy_low"}, rdy_bad, 0);
    check({name, "_nwords"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      o  = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;
      ol = (i < got_l.size()) ? got_l[i] : 1'bx;
      check($sformatf("%s_w%0d", name, i), o, exp_d[i]);
      check($sformatf("%s_l%0d", name, i), {31'b0, ol}, (i == exp_d.size() - 1) ? 32'd1 : 32'd0);
    end
    got_d.delete();
    got_l.delete();
    exp_d.delete();
  endtask

  task automatic msg_abc(input string name);
    exp_d.push_back(32'h61626380); push_zero(14); exp_d.push_back(32'h00000018);
    send_beat(32'h61626300, 4'b1110, 1'b1);
    finish_msg(name);
  endtask

  task automatic msg_56(input string name);
    for (int i = 0; i < 14; i++) exp_d.push_back(32'h61626364);
    exp_d.push_back(32'h80000000); push_zero(15); exp_d.push_back(32'h0);
    exp_d.push_back(32'h000001C0);
    for (int i = 0; i < 14; i++) send_beat(32'h61626364, 4'b1111, i == 13);
    finish_msg(name);
  endtask

  initial begin
    bus.msg_inpt_d_i        = '0;
    bus.msg_inpt_vld_byte_i = '0;
    bus.msg_inpt_vld_i      = 1'b0;
    bus.msg_inpt_lst_i      = 1'b0;

    // reset state
    #2;
    check("rst_rdy", {31'b0, bus.msg_inpt_rdy_o}, 32'd0);
    check("rst_vld", {31'b0, bus.pad_otpt_vld_o}, 32'd0);
    check("rst_lst", {31'b0, bus.pad_otpt_lst_o}, 32'd0);
    check("rst_d", bus.pad_otpt_d_o, 32'd0);
`ifdef SM3_PAD_ERR_CHK_EN
    check("rst_err", {31'b0, bus.pad_err_o}, 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_rdy", {31'b0, bus.msg_inpt_rdy_o}, 32'd1);
    @(posedge clk); #1;

    msg_abc("abc");

    // single byte with garbage in the invalid bytes
    exp_d.push_back(32'h61800000); push_zero(14); exp_d.push_back(32'h00000008);
    send_beat(32'h61FFFFFF, 4'b1000, 1'b1);
    finish_msg("one_byte");

    // 64 bytes: whole padding block follows
    for (int i = 0; i < 16; i++) exp_d.push_back(32'h61626364);
    exp_d.push_back(32'h80000000); push_zero(14); exp_d.push_back(32'h00000200);
    for (int i = 0; i < 16; i++) send_beat(32'h61626364, 4'b1111, i == 15);
    finish_msg("b64");

    msg_56("b56");

    // empty message
    exp_d.push_back(32'h80000000); push_zero(15);
    send_beat(32'h0, 4'b0000, 1'b1);
    finish_msg("empty");

    // random back-pressure
    rnd_ena = 1'b1;
    stall_bad = 0;
    msg_abc("abc_bp");
    msg_56("b56_bp");
    rnd_ena = 1'b0;
    check("stall_hold", stall_bad, 0);
    @(posedge clk); #1;

    // reset in the middle of a message
    for (int i = 0; i < 5; i++) send_beat(32'h01020304 + i, 4'b1111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'b0, bus.pad_otpt_vld_o}, 32'd0);
    check("mid_rst_d", bus.pad_otpt_d_o, 32'd0);
    check("mid_rst_rdy", {31'b0, bus.msg_inpt_rdy_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_d.delete();
    got_l.delete();
    @(posedge clk); #1;
    msg_abc("abc_after_rst");

`ifdef SM3_PAD_ERR_CHK_EN
    check("err_clean", {31'b0, bus.pad_err_o}, 32'd0);
    send_beat(32'h11223344, 4'b1010, 1'b0);
    check("err_set", {31'b0, bus.pad_err_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", {31'b0, bus.pad_err_o}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
